// File: rtl/conv1_event_scheduler_pkg.sv
// Shared definitions for the conv1 event scheduler slice.
// Holds the layer-wide coordinate limit, the default event FIFO depth and
// start timeout, the one-hot scheduler state type, the AER coordinate
// layout, and the legal-range helper used when events are accepted.
package conv1_event_scheduler_pkg;

  localparam int unsigned conv1_max_coord        = 27;
  localparam int unsigned conv1_sched_fifo_depth = 8;
  localparam int unsigned conv1_start_timeout    = 4;

  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_ISSUE      = 5'b00010,
    S_WAIT_START = 5'b00100,
    S_BUSY       = 5'b01000,
    S_TS_DONE    = 5'b10000
  } sched_state_e;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } aer_coord_t;

  function automatic logic coord_in_range(input logic [15:0] ev,
                                          input int unsigned max_coord);
    aer_coord_t c;
    c = ev;
    return (32'(c.row) <= max_coord) && (32'(c.col) <= max_coord);
  endfunction

endpackage

// File: rtl/conv1_event_scheduler_if.sv
// Event-side bundle of the conv1 scheduler.
//   req_valid/req_aer0/req_aer1/req_ready : two-channel AER request handshake
//   ts_end/ts_done                         : timestep close request / ack
//   aer_out/aer_flag/operating_flag        : address-generator side
//   drop_cnt/timeout_err                   : status
// master = event sources + generator, slave = scheduler.
interface conv1_event_scheduler_if;
  logic [1:0]  req_valid;
  logic [15:0] req_aer0;
  logic [15:0] req_aer1;
  logic [1:0]  req_ready;
  logic        ts_end;
  logic        ts_done;
  logic [15:0] aer_out;
  logic        aer_flag;
  logic        operating_flag;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  modport master (
    output req_valid, req_aer0, req_aer1, ts_end, operating_flag,
    input  req_ready, ts_done, aer_out, aer_flag, drop_cnt, timeout_err
  );

  modport slave (
    input  req_valid, req_aer0, req_aer1, ts_end, operating_flag,
    output req_ready, ts_done, aer_out, aer_flag, drop_cnt, timeout_err
  );
endinterface

// File: rtl/aer_sync_fifo.sv
// Single-clock FIFO for AER events, shared by the layer schedulers.
//   work_clk, rst_n  : clock, asynchronous active-low reset (flushes pointers)
//   push_i, data_i   : write request / data (ignored when full)
//   pop_i, data_o    : read request / head entry (show-ahead)
//   full_o, empty_o  : status flags
// Pointers carry one extra wrap bit: full when wrap bits differ and
// address bits match, empty when the pointers are identical.
module aer_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             work_clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge work_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/conv1_event_scheduler.sv
// conv1 event scheduler: arbitrates two AER request channels round-robin,
// drops out-of-range coordinates, buffers events in aer_sync_fifo and
// issues them one at a time to the address generator as a one-cycle
// aer_flag, holding aer_out until the generator's operating_flag run ends.
// Also closes timesteps: ts_end is answered with a single ts_done once
// every event accepted before it has been processed.
//   work_clk, rst_n : clock, asynchronous active-low reset
//   ev (slave)      : request channels, timestep handshake, generator side,
//                     drop counter and sticky start-timeout error
module conv1_event_scheduler
  import conv1_event_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = conv1_sched_fifo_depth,
  parameter int unsigned START_TIMEOUT = conv1_start_timeout,
  parameter int unsigned MAX_COORD     = conv1_max_coord
) (
  input  logic                   work_clk,
  input  logic                   rst_n,
  conv1_event_scheduler_if.slave ev
);
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  logic [1:0]   ready;
  logic         accept;
  logic [15:0]  acc_ev;
  logic         push;
  logic         pop;
  logic [15:0]  fifo_rd;
  logic         fifo_full;
  logic         fifo_empty;

  logic         rr_q;
  logic         ts_pending_q;
  logic [7:0]   drop_cnt_q;
  sched_state_e state_q;
  logic [15:0]  aer_out_q;
  logic         aer_flag_q;
  logic         ts_done_q;
  logic         timeout_err_q;
  logic [TW-1:0] wait_cnt_q;

  // Grant is one-hot and only offered to a valid channel, so a lone
  // requester is served regardless of where the pointer sits.
  always_comb begin
    ready = '0;
    if (!fifo_full) begin
      if (&ev.req_valid)       ready = rr_q ? 2'b10 : 2'b01;
      else if (ev.req_valid[0]) ready = 2'b01;
      else if (ev.req_valid[1]) ready = 2'b10;
    end
    accept = |(ready & ev.req_valid);
    acc_ev = ready[1] ? ev.req_aer1 : ev.req_aer0;
    push   = accept && coord_in_range(acc_ev, MAX_COORD);
    pop    = (state_q == S_IDLE) && !fifo_empty;
  end

  aer_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .work_clk (work_clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .data_i   (acc_ev),
    .pop_i    (pop),
    .data_o   (fifo_rd),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= 1'b0;
      drop_cnt_q   <= '0;
      ts_pending_q <= 1'b0;
    end else begin
      if (accept && (&ev.req_valid)) rr_q <= ~rr_q;
      if (accept && !push && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      // The ack cycle clears the request; a ts_end landing on that same
      // cycle is absorbed into the timestep being closed.
      if (state_q == S_TS_DONE)  ts_pending_q <= 1'b0;
      else if (ev.ts_end)        ts_pending_q <= 1'b1;
    end
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      aer_out_q     <= '0;
      aer_flag_q    <= 1'b0;
      ts_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      aer_flag_q <= 1'b0;
      ts_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Queued events win over the timestep close, so everything
          // accepted before ts_end is issued first.
          if (!fifo_empty) begin
            aer_out_q  <= fifo_rd;
            aer_flag_q <= 1'b1;
            state_q    <= S_ISSUE;
          end else if (ts_pending_q) begin
            ts_done_q <= 1'b1;
            state_q   <= S_TS_DONE;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (ev.operating_flag) begin
            state_q <= S_BUSY;
          end else if (wait_cnt_q == TW'(START_TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_BUSY: begin
          if (!ev.operating_flag) state_q <= S_IDLE;
        end
        S_TS_DONE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign ev.req_ready   = ready;
  assign ev.aer_out     = aer_out_q;
  assign ev.aer_flag    = aer_flag_q;
  assign ev.ts_done     = ts_done_q;
  assign ev.drop_cnt    = drop_cnt_q;
  assign ev.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_conv1_event_scheduler.sv
// Bench for conv1_event_scheduler: a generator model answers aer_flag by
// raising operating_flag two cycles later for a few cycles; every issued
// event is compared against a scoreboard queue filled as stimulus is driven.
module tb_conv1_event_scheduler;
  localparam int unsigned BUSY_LEN = 3;
  localparam int unsigned TMO      = 4;

  logic work_clk = 1'b0;
  logic rst_n;
  conv1_event_scheduler_if bus();

  conv1_event_scheduler #(
    .FIFO_DEPTH    (8),
    .START_TIMEOUT (TMO),
    .MAX_COORD     (27)
  ) dut (
    .work_clk (work_clk),
    .rst_n    (rst_n),
    .ev       (bus)
  );

  always #5 work_clk = ~work_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  int exp_drop = 0;

  // generator model state
  logic gen_hold = 1'b0;
  logic gen_dead = 1'b0;
  int gen_phase = 0;
  int gen_cnt = 0;
  int flag_cnt = 0;
  int runs_done = 0;
  int ts_done_cnt = 0;
  int runs_at_ts = 0;
  int qsize_at_ts = 0;
  int to_cnt = 0;
  int to_lat = -1;
  logic to_prev = 1'b0;
  logic [15:0] held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [15:0] e);
    return (e[15:8] <= 8'd27) && (e[7:0] <= 8'd27);
  endfunction

  // Generator model and output monitor, sampled 1ns after each edge.
  always @(posedge work_clk) begin
    #1;
    if (!rst_n) begin
      gen_phase = 0;
      gen_cnt = 0;
      bus.operating_flag = 1'b0;
      to_prev = 1'b0;
    end else begin
      if (bus.aer_flag) begin
        flag_cnt++;
        check_eq("flag_spacing", gen_phase, 0);
        if (exp_q.size() == 0) check_eq("unexpected_flag", 1, 0);
        else check_eq("aer_out", bus.aer_out, exp_q.pop_front());
        held = bus.aer_out;
        gen_cnt = 0;
        gen_phase = gen_dead ? 0 : 1;
        to_cnt = 0;
      end else begin
        gen_cnt++;
        to_cnt++;
        if (gen_phase != 0) check_eq("aer_out_hold", bus.aer_out, held);
        if (gen_phase == 1 && gen_cnt == 2) begin
          bus.operating_flag = 1'b1;
          gen_phase = 2;
          gen_cnt = 0;
        end else if (gen_phase == 2 && gen_cnt >= BUSY_LEN && !gen_hold) begin
          bus.operating_flag = 1'b0;
          gen_phase = 0;
          runs_done++;
        end
      end
      if (bus.timeout_err && !to_prev) to_lat = to_cnt;
      to_prev = bus.timeout_err;
      if (bus.ts_done) begin
        ts_done_cnt++;
        runs_at_ts = runs_done;
        qsize_at_ts = exp_q.size();
      end
    end
  end

  task automatic send(input int ch, input logic [15:0] e, output int waited);
    logic ok = 1'b0;
    waited = 0;
    bus.req_valid[ch] = 1'b1;
    if (ch == 0) bus.req_aer0 = e; else bus.req_aer1 = e;
    for (int i = 0; i < 200; i++) begin
      @(negedge work_clk);
      if (bus.req_ready[ch]) begin ok = 1'b1; break; end
      waited++;
    end
    if (ok) begin
      if (legal(e)) exp_q.push_back(e);
      else if (exp_drop < 255) exp_drop++;
    end else check_eq("send_timeout", 0, 1);
    @(posedge work_clk); #1;
    bus.req_valid[ch] = 1'b0;
  endtask

  task automatic wait_drain();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 8; i++) begin
      @(posedge work_clk); #1;
      if (exp_q.size() == 0 && gen_phase == 0 && !bus.aer_flag) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 30 && !bus.operating_flag; i++) @(posedge work_clk);
    #1;
    check_eq("busy_reached", bus.operating_flag, 1);
  endtask

  initial begin
    int w;
    int base;
    int base2;
    logic exp_rr;
    logic [1:0] expr;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_aer0 = '0;
    bus.req_aer1 = '0;
    bus.ts_end = 1'b0;
    bus.operating_flag = 1'b0;
    repeat (3) @(negedge work_clk);
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_aer_out", bus.aer_out, 0);
    check_eq("rst_flag", bus.aer_flag, 0);
    check_eq("rst_ts_done", bus.ts_done, 0);
    check_eq("rst_drop", bus.drop_cnt, 0);
    check_eq("rst_timeout", bus.timeout_err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge work_clk);
    #1;

    // single event latency: accept at edge N, flag visible after edge N+1
    send(0, 16'h0305, w);
    check_eq("lat_wait", w, 0);
    check_eq("lat_edge_n", bus.aer_flag, 0);
    @(posedge work_clk); #1;
    check_eq("lat_edge_n1", bus.aer_flag, 1);
    check_eq("lat_aer_out", bus.aer_out, 16'h0305);
    wait_drain();

    // round robin with both channels continuously valid
    q0 = '{16'h0101, 16'h0102};
    q1 = '{16'h0201, 16'h0202};
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0202);
    exp_rr = 1'b0;
    for (int cyc = 0; cyc < 50 && (q0.size() != 0 || q1.size() != 0); cyc++) begin
      bus.req_valid = {q1.size() != 0, q0.size() != 0};
      bus.req_aer0 = (q0.size() != 0) ? q0[0] : 16'h0;
      bus.req_aer1 = (q1.size() != 0) ? q1[0] : 16'h0;
      @(negedge work_clk);
      if (&bus.req_valid) expr = exp_rr ? 2'b10 : 2'b01;
      else expr = bus.req_valid;
      check_eq("rr_ready", bus.req_ready, expr);
      if (&bus.req_valid) exp_rr = ~exp_rr;
      if (expr[0]) void'(q0.pop_front()); else void'(q1.pop_front());
      @(posedge work_clk); #1;
    end
    bus.req_valid = '0;
    wait_drain();

    // fill the FIFO while the generator is held busy
    base = flag_cnt;
    gen_hold = 1'b1;
    send(0, 16'h0001, w);
    wait_busy();
    for (int i = 1; i <= 8; i++) begin
      send(0, {8'(i), 8'(i + 1)}, w);
      check_eq("fill_ready", w, 0);
    end
    bus.req_aer0 = 16'h090A;
    bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge work_clk);
      check_eq("full_stall", bus.req_ready, 0);
    end
    gen_hold = 1'b0;
    send(0, 16'h090A, w);
    wait_drain();
    check_eq("full_flags", flag_cnt - base, 10);

    // out-of-range drops, plus the largest legal coordinate
    base = flag_cnt;
    send(0, 16'h1C00, w);
    wait_drain();
    check_eq("drop_row", bus.drop_cnt, exp_drop);
    check_eq("drop_no_flag", flag_cnt - base, 0);
    send(1, 16'h001C, w);
    send(0, 16'h1B1B, w);
    wait_drain();
    check_eq("drop_col", bus.drop_cnt, exp_drop);
    check_eq("edge_coord_flag", flag_cnt - base, 1);

    // timestep close with 3 events queued; the second ts_end is absorbed
    base = runs_done;
    base2 = ts_done_cnt;
    send(0, 16'h0A0A, w);
    send(0, 16'h0B0B, w);
    send(0, 16'h0C0C, w);
    bus.ts_end = 1'b1;
    @(posedge work_clk); #1;
    bus.ts_end = 1'b0;
    repeat (2) @(posedge work_clk);
    #1;
    check_eq("ts_not_early", ts_done_cnt - base2, 0);
    bus.ts_end = 1'b1;
    @(posedge work_clk); #1;
    bus.ts_end = 1'b0;
    wait_drain();
    check_eq("ts_done_once", ts_done_cnt - base2, 1);
    check_eq("ts_after_runs", runs_at_ts - base, 3);
    check_eq("ts_queue_empty", qsize_at_ts, 0);

    // generator never starts: timeout, then the next event still issues
    base = flag_cnt;
    gen_dead = 1'b1;
    send(0, 16'h0404, w);
    send(0, 16'h0505, w);
    check_eq("to_before", bus.timeout_err, 0);
    wait_drain();
    check_eq("to_sticky", bus.timeout_err, 1);
    check_eq("to_latency", to_lat, 1 + TMO);
    check_eq("to_next_issued", flag_cnt - base, 2);
    gen_dead = 1'b0;
    repeat (4) @(posedge work_clk);

    // asynchronous reset while an event is in flight and two are queued
    gen_hold = 1'b1;
    send(0, 16'h0606, w);
    wait_busy();
    send(0, 16'h0707, w);
    send(0, 16'h0808, w);
    @(posedge work_clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_flag", bus.aer_flag, 0);
    check_eq("arst_aer_out", bus.aer_out, 0);
    check_eq("arst_timeout", bus.timeout_err, 0);
    check_eq("arst_drop", bus.drop_cnt, 0);
    exp_q.delete();
    gen_hold = 1'b0;
    repeat (2) @(negedge work_clk);
    rst_n = 1'b1;
    base = flag_cnt;
    repeat (15) @(posedge work_clk);
    #1;
    check_eq("arst_flushed", flag_cnt - base, 0);
    send(0, 16'h0909, w);
    wait_drain();
    check_eq("arst_recover", flag_cnt - base, 1);
    check_eq("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
